// File: rtl/cl_fetch_rsp.sv
// rtl/cl_fetch_rsp.sv - cacheline fetch responder: round-robin request arbitration, tagged memory reads, BRAM fill
module cl_fetch_rsp #(
  parameter int nstreams   = 8,
  parameter int ncl        = 16,
  parameter int clid_width = $clog2(ncl),
  parameter int sid_width  = $clog2(nstreams),
  parameter int addr_width = 64,
  parameter int cl_bytes   = 128,
  parameter int data_width = 1024,
  parameter int max_outst  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [nstreams-1:0]             i_rst_v,
  output logic [nstreams-1:0]             i_rst_r,
  input  logic [nstreams*addr_width-1:0]  i_rst_addr,
  input  logic [nstreams-1:0]             i_clreq_v,
  output logic [nstreams-1:0]             i_clreq_r,
  output logic                            o_mreq_v,
  input  logic                            o_mreq_r,
  output logic [addr_width-1:0]           o_mreq_addr,
  output logic [sid_width+clid_width-1:0] o_mreq_tag,
  input  logic                            i_mrsp_v,
  output logic                            i_mrsp_r,
  input  logic [sid_width+clid_width-1:0] i_mrsp_tag,
  input  logic [data_width-1:0]           i_mrsp_d,
  output logic                            o_wr_v,
  output logic [sid_width+clid_width-1:0] o_wr_addr,
  output logic [data_width-1:0]           o_wr_d,
  output logic [nstreams-1:0]             o_clrsp_v
);
  localparam int tag_width  = sid_width + clid_width;
  localparam int ocnt_width = $clog2(ncl + 1);
  localparam int tcnt_width = $clog2(max_outst + 1);
  localparam logic [tcnt_width-1:0] tcnt_max  = tcnt_width'(max_outst);
  localparam logic [clid_width-1:0] clid_last = clid_width'(ncl - 1);
  localparam logic [sid_width-1:0]  sid_last  = sid_width'(nstreams - 1);
  localparam logic [sid_width:0]    ns_wide   = (sid_width + 1)'(nstreams);
  localparam logic [addr_width-1:0] addr_step = addr_width'(cl_bytes);

  logic [addr_width-1:0] r_nxt_addr  [nstreams];
  logic [clid_width-1:0] r_fill_clid [nstreams];
  logic [ocnt_width-1:0] r_ocnt      [nstreams];
  logic [tcnt_width-1:0] r_tcnt;
  logic [sid_width-1:0]  r_rr;

  logic                 w_load_en;
  logic                 w_can_issue;
  logic                 w_found;
  logic                 w_fire;
  logic                 w_rsp_ok;
  logic [nstreams-1:0]  w_elig;
  logic [nstreams-1:0]  w_grant;
  logic [nstreams-1:0]  w_inc;
  logic [nstreams-1:0]  w_dec;
  logic [sid_width-1:0] w_gnt_sid;
  logic [sid_width-1:0] w_rsp_sid;

  assign w_load_en   = ~o_mreq_v | o_mreq_r;
  assign w_can_issue = w_load_en & (r_tcnt < tcnt_max);
  assign w_elig      = i_clreq_v & ~i_rst_v;
  assign w_fire      = w_can_issue & w_found;
  assign i_clreq_r   = w_can_issue ? w_grant : '0;
  assign i_mrsp_r    = 1'b1;

  // Tags for streams with nothing in flight are dropped rather than underflowing the counters.
  assign w_rsp_sid = i_mrsp_tag[tag_width-1 -: sid_width];
  assign w_rsp_ok  = i_mrsp_v & (r_ocnt[w_rsp_sid] != '0);

  // First eligible stream at or after the round-robin pointer.
  always_comb begin
    logic [sid_width:0]   idx_w;
    logic [sid_width-1:0] idx;
    w_found   = 1'b0;
    w_gnt_sid = '0;
    w_grant   = '0;
    idx_w     = '0;
    idx       = '0;
    for (int k = 0; k < nstreams; k++) begin
      idx_w = {1'b0, r_rr} + (sid_width + 1)'(k);
      if (idx_w >= ns_wide) idx_w = idx_w - ns_wide;
      idx = idx_w[sid_width-1:0];
      if (!w_found && w_elig[idx]) begin
        w_found      = 1'b1;
        w_gnt_sid    = idx;
        w_grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    i_rst_r = '0;
    w_inc   = '0;
    w_dec   = '0;
    for (int s = 0; s < nstreams; s++) begin
      i_rst_r[s] = (r_ocnt[s] == '0);
      w_inc[s]   = w_fire & w_grant[s];
      w_dec[s]   = w_rsp_ok & (w_rsp_sid == sid_width'(s));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < nstreams; s++) begin
        r_nxt_addr[s]  <= '0;
        r_fill_clid[s] <= '0;
        r_ocnt[s]      <= '0;
      end
      r_tcnt      <= '0;
      r_rr        <= '0;
      o_mreq_v    <= 1'b0;
      o_mreq_addr <= '0;
      o_mreq_tag  <= '0;
      o_wr_v      <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_d      <= '0;
      o_clrsp_v   <= '0;
    end else begin
      for (int s = 0; s < nstreams; s++) begin
        if (i_rst_v[s] && i_rst_r[s]) begin
          r_nxt_addr[s]  <= i_rst_addr[s*addr_width +: addr_width];
          r_fill_clid[s] <= '0;
        end else if (w_inc[s]) begin
          r_nxt_addr[s]  <= r_nxt_addr[s] + addr_step;
          r_fill_clid[s] <= (r_fill_clid[s] == clid_last) ? '0 : r_fill_clid[s] + 1'b1;
        end
        if (w_inc[s] && !w_dec[s]) r_ocnt[s] <= r_ocnt[s] + 1'b1;
        else if (w_dec[s] && !w_inc[s]) r_ocnt[s] <= r_ocnt[s] - 1'b1;
      end
      if (w_fire && !w_rsp_ok) r_tcnt <= r_tcnt + 1'b1;
      else if (w_rsp_ok && !w_fire) r_tcnt <= r_tcnt - 1'b1;
      if (w_load_en) o_mreq_v <= w_fire;
      if (w_fire) begin
        o_mreq_addr <= r_nxt_addr[w_gnt_sid];
        o_mreq_tag  <= {w_gnt_sid, r_fill_clid[w_gnt_sid]};
        r_rr        <= (w_gnt_sid == sid_last) ? '0 : w_gnt_sid + 1'b1;
      end
      o_wr_v    <= w_rsp_ok;
      o_clrsp_v <= w_dec;
      if (w_rsp_ok) begin
        o_wr_addr <= i_mrsp_tag;
        o_wr_d    <= i_mrsp_d;
      end
    end
  end

  a_rsp_sid_live: assert property (@(posedge clk) disable iff (!reset)
    i_mrsp_v |-> (r_ocnt[w_rsp_sid] != '0));

endmodule

// File: tb/tb_cl_fetch_rsp.sv
// tb/tb_cl_fetch_rsp.sv - directed and randomized checks of cl_fetch_rsp against a behavioural model
module tb_cl_fetch_rsp;
  localparam int NS = 8, NCL = 16, CW = 4, SW = 3, AW = 64, CLB = 128, DW = 1024, MAXO = 8;
  localparam int TW = SW + CW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NS-1:0]     i_rst_v, i_rst_r, i_clreq_v, i_clreq_r, o_clrsp_v;
  logic [NS*AW-1:0]  i_rst_addr;
  logic              o_mreq_v, o_mreq_r, i_mrsp_v, i_mrsp_r, o_wr_v;
  logic [AW-1:0]     o_mreq_addr;
  logic [TW-1:0]     o_mreq_tag, i_mrsp_tag, o_wr_addr;
  logic [DW-1:0]     i_mrsp_d, o_wr_d;

  cl_fetch_rsp #(
    .nstreams(NS), .ncl(NCL), .clid_width(CW), .sid_width(SW), .addr_width(AW),
    .cl_bytes(CLB), .data_width(DW), .max_outst(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_addr(i_rst_addr),
    .i_clreq_v(i_clreq_v), .i_clreq_r(i_clreq_r),
    .o_mreq_v(o_mreq_v), .o_mreq_r(o_mreq_r), .o_mreq_addr(o_mreq_addr), .o_mreq_tag(o_mreq_tag),
    .i_mrsp_v(i_mrsp_v), .i_mrsp_r(i_mrsp_r), .i_mrsp_tag(i_mrsp_tag), .i_mrsp_d(i_mrsp_d),
    .o_wr_v(o_wr_v), .o_wr_addr(o_wr_addr), .o_wr_d(o_wr_d), .o_clrsp_v(o_clrsp_v)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] fold(input logic [DW-1:0] d);
    logic [63:0] r, w;
    r = '0;
    for (int i = 0; i < DW/64; i++) begin
      w = d[i*64 +: 64];
      r ^= (w << i) | (w >> (64 - i));
    end
    return r;
  endfunction

  // Behavioural model: per-stream address/slot/in-flight count, issue register, write port.
  logic [AW-1:0] m_addr [NS];
  int            m_clid [NS];
  int            m_ocnt [NS];
  int            m_rr;
  logic          m_mreq_v, m_wr_v;
  logic [AW-1:0] m_mreq_addr;
  logic [TW-1:0] m_mreq_tag, m_wr_addr;
  logic [DW-1:0] m_wr_d, rsp_d_last;
  logic [NS-1:0] m_clrsp;

  logic [TW-1:0] pend [$];
  logic [AW-1:0] log_addr [$];
  logic [TW-1:0] log_tag [$];

  logic [NS-1:0] want_req, want_rst, seen_clreq_r, seen_rst_r;
  int            p_mreq_r, p_rsp, force_tag;
  bit            rand_mode;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_addr[i] = '0; m_clid[i] = 0; m_ocnt[i] = 0;
    end
    m_rr = 0; m_mreq_v = 0; m_mreq_addr = '0; m_mreq_tag = '0;
    m_wr_v = 0; m_wr_addr = '0; m_wr_d = '0; m_clrsp = '0;
  endtask

  task automatic clear_inputs();
    i_rst_v = '0; i_clreq_v = '0; o_mreq_r = 1'b0; i_mrsp_v = 1'b0;
    i_mrsp_tag = '0; i_mrsp_d = '0;
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cycle();
    int sum, g, s, pick;
    bit load_en, can_issue;
    logic [NS-1:0] elig, exp_clreq_r, exp_rst_r;
    logic [DW-1:0] d;
    chk("mreq_v", o_mreq_v, m_mreq_v);
    if (m_mreq_v) begin
      chk("mreq_addr", o_mreq_addr, m_mreq_addr);
      chk("mreq_tag", o_mreq_tag, m_mreq_tag);
    end
    chk("wr_v", o_wr_v, m_wr_v);
    chk("clrsp_v", o_clrsp_v, m_clrsp);
    if (m_wr_v) begin
      chk("wr_addr", o_wr_addr, m_wr_addr);
      chk("wr_d", fold(o_wr_d), fold(m_wr_d));
    end

    if (rand_mode) begin
      i_clreq_v = want_req & NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        i_rst_v[i] = ($urandom_range(99) < 3);
        if (i_rst_v[i]) i_rst_addr[i*AW +: AW] = {$urandom, $urandom};
      end
    end else begin
      i_clreq_v = want_req;
      i_rst_v   = want_rst;
    end
    o_mreq_r = ($urandom_range(99) < p_mreq_r);
    i_mrsp_v = 1'b0;
    pick = -1;
    if (force_tag >= 0) begin
      foreach (pend[i]) if (pick < 0 && pend[i] == TW'(force_tag)) pick = i;
      if (pick < 0) begin
        n_chk++;
        $display("FAIL force_tag: tag 0x%0h not in flight", force_tag);
      end
      force_tag = -1;
    end else if (pend.size() > 0 && $urandom_range(99) < p_rsp) begin
      pick = $urandom_range(pend.size() - 1);
    end
    if (pick >= 0) begin
      i_mrsp_v   = 1'b1;
      i_mrsp_tag = pend[pick];
      pend.delete(pick);
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      i_mrsp_d   = d;
      rsp_d_last = d;
    end
    #1;

    sum = 0;
    foreach (m_ocnt[i]) sum += m_ocnt[i];
    load_en   = !m_mreq_v || o_mreq_r;
    can_issue = load_en && (sum < MAXO);
    elig = i_clreq_v & ~i_rst_v;
    g = -1;
    for (int k = 0; k < NS; k++) begin
      s = (m_rr + k) % NS;
      if (g < 0 && elig[s]) g = s;
    end
    exp_clreq_r = '0;
    if (can_issue && g >= 0) exp_clreq_r[g] = 1'b1;
    for (int i = 0; i < NS; i++) exp_rst_r[i] = (m_ocnt[i] == 0);
    chk("clreq_r", i_clreq_r, exp_clreq_r);
    chk("rst_r", i_rst_r, exp_rst_r);
    chk("mrsp_r", i_mrsp_r, 1'b1);
    seen_clreq_r = i_clreq_r;
    seen_rst_r   = i_rst_r;

    if (o_mreq_v && o_mreq_r) begin
      log_addr.push_back(o_mreq_addr);
      log_tag.push_back(o_mreq_tag);
    end
    if (m_mreq_v && o_mreq_r) pend.push_back(m_mreq_tag);
    for (int i = 0; i < NS; i++) begin
      if (i_rst_v[i] && m_ocnt[i] == 0) begin
        m_addr[i] = i_rst_addr[i*AW +: AW];
        m_clid[i] = 0;
      end
    end
    m_wr_v  = i_mrsp_v;
    m_clrsp = '0;
    if (i_mrsp_v) begin
      m_wr_addr  = i_mrsp_tag;
      m_wr_d     = i_mrsp_d;
      s          = int'(i_mrsp_tag) / NCL;
      m_clrsp[s] = 1'b1;
      m_ocnt[s]--;
    end
    if (can_issue && g >= 0) begin
      m_mreq_v    = 1'b1;
      m_mreq_addr = m_addr[g];
      m_mreq_tag  = TW'(g * NCL + m_clid[g]);
      m_addr[g]   = m_addr[g] + AW'(CLB);
      m_clid[g]   = (m_clid[g] + 1) % NCL;
      m_ocnt[g]++;
      m_rr        = (g + 1) % NS;
    end else if (load_en) begin
      m_mreq_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    want_req = '0; want_rst = '0; p_mreq_r = 100; p_rsp = 100;
    while ((pend.size() > 0 || m_mreq_v) && n < 100) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_idle", i_rst_r, {NS{1'b1}});
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_tag.delete();
  endtask

  initial begin
    int rr_exp [6] = '{0, 3, 5, 0, 3, 5};
    int grants, n;
    logic [TW-1:0] t;

    clear_inputs();
    i_rst_addr = '0;
    model_reset();
    rand_mode = 0; force_tag = -1; p_mreq_r = 100; p_rsp = 0;
    want_req = '0; want_rst = '0;
    repeat (2) @(negedge clk);
    chk("reset_mreq_v", o_mreq_v, 1'b0);
    chk("reset_mreq_addr", o_mreq_addr, 64'h0);
    chk("reset_mreq_tag", o_mreq_tag, 0);
    chk("reset_wr_v", o_wr_v, 1'b0);
    chk("reset_wr_addr", o_wr_addr, 0);
    chk("reset_wr_d", fold(o_wr_d), 64'h0);
    chk("reset_clrsp_v", o_clrsp_v, 0);
    chk("reset_rst_r", i_rst_r, {NS{1'b1}});
    reset = 1'b1;

    // Round-robin among streams 0, 3, 5 from reset
    clear_log();
    want_req = 8'b0010_1001; p_rsp = 100;
    repeat (6) cycle();
    drain();
    chk("rr_count", log_tag.size(), 6);
    for (int i = 0; i < 6 && i < log_tag.size(); i++) begin
      t = log_tag[i];
      chk("rr_order", t[TW-1:CW], rr_exp[i]);
    end

    // Restart stream 2 at 0x1000, three requests
    clear_log();
    p_rsp = 0;
    i_rst_addr[2*AW +: AW] = 64'h1000;
    want_rst = 8'h04;
    cycle();
    want_rst = '0; want_req = 8'h04;
    repeat (3) cycle();
    drain();
    chk("restart_count", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk("restart_addr", log_addr[i], 64'h1000 + 64'(i * CLB));
      chk("restart_tag", log_tag[i], 2 * NCL + i);
    end

    // Outstanding cap: 8 issue, then blocked until one response
    clear_log();
    p_rsp = 0; want_req = 8'h02;
    repeat (10) cycle();
    chk("cap_blocked", seen_clreq_r, 0);
    chk("cap_issued", log_tag.size(), MAXO);
    if (pend.size() > 0) force_tag = int'(pend[0]);
    cycle();
    chk("cap_same_cycle", seen_clreq_r, 0);
    cycle();
    chk("cap_ninth", seen_clreq_r, 8'h02);
    drain();
    chk("cap_total", log_tag.size(), MAXO + 1);

    // 17 requests on stream 1: slot index wraps, address keeps climbing
    clear_log();
    i_rst_addr[1*AW +: AW] = 64'h2_0000;
    want_rst = 8'h02;
    cycle();
    want_rst = '0; want_req = 8'h02; p_rsp = 50;
    grants = 0; n = 0;
    while (grants < 17 && n < 300) begin
      cycle();
      if (seen_clreq_r[1]) grants++;
      n++;
    end
    drain();
    chk("wrap_count", log_tag.size(), 17);
    if (log_tag.size() >= 17) begin
      chk("wrap_tag", log_tag[16], 1 * NCL + 0);
      chk("wrap_addr", log_addr[16], 64'h2_0000 + 64'(16 * CLB));
    end

    // Out-of-order response {4,7}
    p_rsp = 0; want_req = 8'h10;
    repeat (8) cycle();
    want_req = '0;
    repeat (2) cycle();
    force_tag = 4 * NCL + 7;
    cycle();
    chk("ooo_wr_v", o_wr_v, 1'b1);
    chk("ooo_wr_addr", o_wr_addr, 4 * NCL + 7);
    chk("ooo_wr_d", fold(o_wr_d), fold(rsp_d_last));
    chk("ooo_clrsp_v", o_clrsp_v, 8'h10);
    drain();

    // Stream 6 restart while two reads are in flight
    clear_log();
    p_rsp = 0; want_req = 8'h40;
    i_rst_addr[6*AW +: AW] = 64'h5000;
    repeat (2) cycle();
    want_rst = 8'h40;
    repeat (2) cycle();
    chk("busy_rst_r", seen_rst_r[6], 1'b0);
    chk("busy_no_grant", seen_clreq_r[6], 1'b0);
    force_tag = 6 * NCL + 0;
    cycle();
    chk("first_rsp_rst_r", seen_rst_r[6], 1'b0);
    force_tag = 6 * NCL + 1;
    cycle();
    chk("last_rsp_rst_r", seen_rst_r[6], 1'b0);
    cycle();
    chk("free_rst_r", seen_rst_r[6], 1'b1);
    chk("free_no_grant", seen_clreq_r[6], 1'b0);
    want_rst = '0;
    cycle();
    chk("regrant", seen_clreq_r[6], 1'b1);
    drain();
    chk("restart6_count", log_tag.size(), 3);
    if (log_tag.size() >= 3) begin
      chk("restart6_addr", log_addr[2], 64'h5000);
      chk("restart6_tag", log_tag[2], 6 * NCL + 0);
    end

    // Randomized traffic
    rand_mode = 1; p_mreq_r = 70; p_rsp = 40; want_req = '1;
    repeat (2000) cycle();

    // Asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1;
    chk("areset_mreq_v", o_mreq_v, 1'b0);
    chk("areset_wr_v", o_wr_v, 1'b0);
    chk("areset_clrsp_v", o_clrsp_v, 0);
    chk("areset_rst_r", i_rst_r, {NS{1'b1}});
    pend.delete();
    clear_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (300) cycle();
    rand_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cl_fetch_rsp.md
# cl_fetch_rsp

Cacheline fetch responder: the L2-side end of the per-stream cacheline request/response handshake. It arbitrates round-robin among `nstreams` cacheline requests and tracks per-stream fill slot and memory address. It issues tagged memory reads, writes returned lines into the stream buffer BRAM, and pulses the per-stream response that increments the requester's valid-line count.

## Interface
- `nstreams`, 8: number of streams.
- `ncl`, 16: cachelines per stream (buffer slots).
- `clid_width`, $clog2(ncl): slot index width.
- `sid_width`, $clog2(nstreams): stream id width.
- `addr_width`, 64: memory byte address width.
- `cl_bytes`, 128: address increment per cacheline.
- `data_width`, 1024: cacheline data width.
- `max_outst`, 8: maximum memory reads in flight (all streams).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `i_rst_v`, `i_rst_r` in/out nstreams: per-stream restart handshake.
- `i_rst_addr` in nstreams*addr_width: start address per stream; stream s occupies slice [s*addr_width +: addr_width].
- `i_clreq_v`, `i_clreq_r` in/out nstreams: per-stream cacheline request handshake.
- `o_mreq_v`, `o_mreq_r` out/in 1: memory read request handshake.
- `o_mreq_addr` out addr_width: read address.
- `o_mreq_tag` out sid_width+clid_width: {sid, clid}.
- `i_mrsp_v`, `i_mrsp_r` in/out 1: memory response handshake; `i_mrsp_r` is constant 1.
- `i_mrsp_tag` in sid_width+clid_width: echoed tag; responses may return out of order.
- `i_mrsp_d` in data_width: line data.
- `o_wr_v` out 1: BRAM write enable.
- `o_wr_addr` out sid_width+clid_width: BRAM write address {sid, clid}.
- `o_wr_d` out data_width: BRAM write data.
- `o_clrsp_v` out nstreams: one-cycle response pulse per stream; the consumer is always ready.

## Operation
- Per-stream state:
  - `nxt_addr` (addr_width): reset 0.
  - `fill_clid` (clid_width): reset 0.
  - `ocnt` (width $clog2(ncl+1)): reads in flight for the stream; reset 0.
- Global state:
  - `tcnt` (width $clog2(max_outst+1)): total reads in flight; reset 0.
  - Round-robin pointer: reset 0, so stream 0 has highest priority first.
- Issue stage is a single output register (`o_mreq_v/addr/tag`).
  - `load_en` = ~o_mreq_v | o_mreq_r.
  - `can_issue` = load_en & (tcnt < max_outst).
- Arbitration:
  - Eligible[s] = i_clreq_v[s] & ~i_rst_v[s].
  - Grant the first eligible stream at or after the RR pointer, wrapping modulo nstreams.
  - `i_clreq_r[s]` = can_issue & grant[s]; at most one bit is set.
- On grant of stream s:
  - Load `o_mreq_addr` = nxt_addr[s] and `o_mreq_tag` = {s, fill_clid[s]}.
  - nxt_addr[s] += cl_bytes, wrapping modulo 2^addr_width.
  - fill_clid[s] += 1, wrapping modulo ncl (ncl-1 → 0 when ncl is not a power of 2).
  - ocnt[s]++, tcnt++.
  - RR pointer = s+1 mod nstreams.
- If load_en is high and there is no grant, o_mreq_v clears.
- Memory response accept (i_mrsp_v, always ready), next cycle:
  - o_wr_v=1, o_wr_addr=i_mrsp_tag, o_wr_d=i_mrsp_d.
  - o_clrsp_v[tag.sid]=1.
  - ocnt[tag.sid]--, tcnt-- (applied at accept).
- Grant and response on the same cycle:
  - tcnt is unchanged.
  - ocnt of the same stream is unchanged; otherwise each stream's count is updated independently.
- Restart:
  - i_rst_r[s] = (ocnt[s]==0).
  - On accept: nxt_addr[s]=i_rst_addr slice, fill_clid[s]=0.
  - A stream with i_rst_v high is never granted, so restart has priority over a simultaneous request and no new read can start during the accept.
- An i_mrsp_tag whose sid has ocnt==0 is a protocol violation: assert in simulation; no counters change.

## Timing
- Reset values: o_mreq_v=0, o_wr_v=0, o_clrsp_v=0, addr/tag/data registers=0, all counters 0.
- Request acceptance → o_mreq_v: 1 cycle.
- Memory response accept → o_wr_v/o_clrsp_v: 1 cycle; the two are always coincident.
- Sustained throughput is one request per cycle while o_mreq_r=1 and tcnt<max_outst.
- When tcnt==max_outst, all i_clreq_r are 0; a response in that cycle frees a slot from the next cycle.
- o_mreq_v/addr/tag are held stable while o_mreq_v=1 & o_mreq_r=0.
- An asynchronous reset mid-operation clears all state immediately. In-flight memory responses after reset release are the system's responsibility and must be drained first.

## Test plan
- Restart stream 2 with addr 0x1000, then 3 requests → o_mreq_addr 0x1000, 0x1080, 0x1100; tags {2,0},{2,1},{2,2}; each issued 1 cycle after accept.
- Streams 0, 3, 5 requesting continuously, o_mreq_r=1 → grants in order 0,3,5,0,3,5; one o_mreq per cycle.
- 9 requests with no responses, max_outst=8 → 8 issued, then all i_clreq_r=0; one response → the 9th issues the next cycle.
- 17 requests on stream 1 (ncl=16) → the 17th tag is {1,0}; its address continues linearly at start+16*128.
- Out-of-order response with tag {4,7} and data D → the next cycle o_wr_addr={4,7}, o_wr_d=D, and only o_clrsp_v[4] pulses.
- Stream 6 with 2 reads in flight raises i_rst_v together with i_clreq_v:
  - i_rst_r=0 and no grant to stream 6 until the second response.
  - i_rst_r=1 the cycle after that response; new addr loaded and fill_clid=0.
